sqrt_iter_hs: RTL and testbench
===============================

Name: sqrt_iter_hs

Overview:
Parametrised iterative integer square root. It is the next-generation replacement for the fixed 32-bit sqrt in the color_transform path, adding a valid/ready handshake, configurable width and throughput, a remainder output, and an optional round-to-nearest mode. It computes floor(sqrt(x)) digit-by-digit at BITS_PER_CYC result bits per clock. An optional clamp keeps a zero result from reaching downstream dividers (std = 0 protection).

Parameters:
IN_W, 32, input width in bits; must be even and >= 4.
BITS_PER_CYC, 1, result bits resolved per clock; must divide IN_W/2.
ROUND, 0, 0 = floor result, 1 = round-to-nearest result.
ZERO_CLAMP, 1, 1 = a final result of 0 is presented as 1.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-high reset.
in_valid  in  1  in_x is valid.
in_ready  out  1  block can accept an operand.
in_x  in  IN_W  unsigned radicand.
out_valid  out  1  result is valid.
out_ready  in  1  consumer accepts the result.
out_y  out  IN_W/2  root after rounding, saturation and clamp.
out_rem  out  IN_W/2+1  floor remainder, x - floor(sqrt(x))^2.
busy  out  1  high in CALC or DONE.

Behaviour:
- Reset (async, immediate): state = IDLE; out_valid = 0, out_y = 0, out_rem = 0, busy = 0. in_ready = 1 once reset deasserts. Reset during CALC or DONE aborts the operation; no result is emitted.
- Let K = (IN_W/2)/BITS_PER_CYC.
- States:
  - IDLE: in_ready = 1. On in_valid & in_ready at edge N, capture in_x, clear the partial root and remainder, load the iteration counter to K-1, and go to CALC.
  - CALC: in_ready = 0. Each edge resolves BITS_PER_CYC root bits, MSB first, using a trial-subtract on the partial remainder. The edge that resolves the last group (edge N+K) registers the final outputs and moves to DONE. out_valid is high from edge N+K onward, so the latency is K cycles from acceptance.
  - DONE: out_valid = 1. out_y and out_rem are held stable while out_ready = 0. On out_valid & out_ready, go to IDLE and drop out_valid.
- No overlap: a new operand is never accepted in CALC or DONE. in_ready rises on the edge after the output handshake completes.
- After acceptance, in_x is not sampled; changes to it do not affect the result.
- Arithmetic:
  - r = floor(sqrt(x)); the result must be exact for all 2^IN_W inputs.
  - rem = x - r^2, always the floor remainder regardless of ROUND. Its range is 0..2r, hence IN_W/2+1 bits.
  - ROUND = 1: y = r+1 when rem > r, else y = r. If r+1 would overflow IN_W/2 bits, y saturates to 2^(IN_W/2)-1.
  - ZERO_CLAMP = 1: if y == 0 then y = 1. The clamp is applied after rounding; rem is unaffected.
- out_y and out_rem change only on the edge entering DONE (or on reset). They keep their last values in IDLE.
- out_valid is never asserted without a preceding accepted operand.

Test Plan:
- Reset, then x=0 (IN_W=32, BITS_PER_CYC=1, ROUND=0, ZERO_CLAMP=1) -> out_y=1, out_rem=0, out_valid high exactly 16 cycles after the accept edge. Repeat with ZERO_CLAMP=0 -> out_y=0.
- x=15 -> ROUND=0: out_y=3, out_rem=6; ROUND=1: out_y=4, out_rem=6. x=16 -> out_y=4, out_rem=0 in both modes.
- x=0xFFFFFFFF -> out_y=65535, out_rem=131070. With ROUND=1, out_y saturates to 65535 (no wrap to 0).
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> out_y and out_rem stable, in_ready=0, and an in_valid pulse during this time is ignored. Raise out_ready -> in_ready=1 on the next cycle. A back-to-back second operand x=1000000 -> out_y=1000, out_rem=0.
- Assert reset at cycle 8 of CALC for x=12345 -> all outputs 0 immediately and no out_valid. Next operand x=12345 -> out_y=111, out_rem=24.
- IN_W=16, BITS_PER_CYC=2: latency 4 cycles. x=65535 -> out_y=255, out_rem=510. A random sweep of 10k operands matches a floor(sqrt) reference model for both ROUND settings.

Source files
------------

// File: rtl/sqrt_iter_hs_if.sv
// rtl/sqrt_iter_hs_if.sv - operand/result handshake bundle for sqrt_iter_hs
interface sqrt_iter_hs_if #(
  parameter int IN_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [IN_W-1:0]   in_x;
  logic              out_valid;
  logic              out_ready;
  logic [IN_W/2-1:0] out_y;
  logic [IN_W/2:0]   out_rem;

  modport slave (
    input  in_valid, in_x, out_ready,
    output in_ready, out_valid, out_y, out_rem
  );

  modport master (
    output in_valid, in_x, out_ready,
    input  in_ready, out_valid, out_y, out_rem
  );
endinterface

// File: rtl/sqrt_iter_hs.sv
// rtl/sqrt_iter_hs.sv - iterative digit-by-digit integer square root with valid/ready handshake
module sqrt_iter_hs #(
  parameter int IN_W         = 32,
  parameter int BITS_PER_CYC = 1,
  parameter int ROUND        = 0,
  parameter int ZERO_CLAMP   = 1
) (
  input  logic          clk,
  input  logic          reset,
  sqrt_iter_hs_if.slave s,
  output logic          busy
);
  localparam int H  = IN_W / 2;
  localparam int K  = H / BITS_PER_CYC;
  localparam int CW = (K > 1) ? $clog2(K) : 1;
  localparam int RW = H + 3;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state, state_nx;
  logic [IN_W-1:0] x_q, x_n;
  logic [H-1:0]    root_q, r_n, y_c, y_q;
  logic [RW-1:0]   rem_q, m_n, trial;
  logic [H:0]      rem_out_q;
  logic [CW-1:0]   cnt_q;
  logic            accept, last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    accept      = 1'b0;
    last        = 1'b0;
    busy        = 1'b0;
    s.in_ready  = 1'b0;
    s.out_valid = 1'b0;
    case (state)
      IDLE: begin
        s.in_ready = 1'b1;
        if (s.in_valid) begin
          accept   = 1'b1;
          state_nx = CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (cnt_q == '0) begin
          last     = 1'b1;
          state_nx = DONE;
        end
      end
      DONE: begin
        busy        = 1'b1;
        s.out_valid = 1'b1;
        if (s.out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Restoring square root: bring down two radicand bits, try subtracting 4*root+1.
  always_comb begin
    r_n   = root_q;
    m_n   = rem_q;
    x_n   = x_q;
    trial = '0;
    for (int i = 0; i < BITS_PER_CYC; i++) begin
      m_n   = {m_n[RW-3:0], x_n[IN_W-1 -: 2]};
      x_n   = x_n << 2;
      trial = {1'b0, r_n, 2'b01};
      if (m_n >= trial) begin
        m_n = m_n - trial;
        r_n = {r_n[H-2:0], 1'b1};
      end else begin
        r_n = {r_n[H-2:0], 1'b0};
      end
    end
    // Rounding saturates at all-ones; clamp follows rounding and never touches rem.
    y_c = r_n;
    if (ROUND != 0 && m_n > {3'b000, r_n})
      y_c = (&r_n) ? r_n : r_n + H'(1);
    if (ZERO_CLAMP != 0 && y_c == '0)
      y_c = H'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q       <= '0;
      root_q    <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      y_q       <= '0;
      rem_out_q <= '0;
    end else if (accept) begin
      x_q    <= s.in_x;
      root_q <= '0;
      rem_q  <= '0;
      cnt_q  <= CW'(K - 1);
    end else if (state == CALC) begin
      x_q    <= x_n;
      root_q <= r_n;
      rem_q  <= m_n;
      cnt_q  <= cnt_q - CW'(1);
      if (last) begin
        y_q       <= y_c;
        rem_out_q <= m_n[H:0];
      end
    end
  end

  assign s.out_y   = y_q;
  assign s.out_rem = rem_out_q;
endmodule

// File: tb/tb_sqrt_iter_hs.sv
// tb/tb_sqrt_iter_hs.sv - directed and swept checks of sqrt_iter_hs in several configurations
module tb_sqrt_iter_hs;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        v32 = 1'b0, r32 = 1'b0;
  logic [31:0] x32 = '0;
  logic        v16 = 1'b0, r16 = 1'b0;
  logic [15:0] x16 = '0;
  logic        busy_a, busy_b, busy_c, busy_d, busy_e;

  sqrt_iter_hs_if #(.IN_W(32)) ia ();
  sqrt_iter_hs_if #(.IN_W(32)) ib ();
  sqrt_iter_hs_if #(.IN_W(32)) ic ();
  sqrt_iter_hs_if #(.IN_W(16)) id ();
  sqrt_iter_hs_if #(.IN_W(16)) ie ();

  assign ia.in_valid = v32; assign ia.in_x = x32; assign ia.out_ready = r32;
  assign ib.in_valid = v32; assign ib.in_x = x32; assign ib.out_ready = r32;
  assign ic.in_valid = v32; assign ic.in_x = x32; assign ic.out_ready = r32;
  assign id.in_valid = v16; assign id.in_x = x16; assign id.out_ready = r16;
  assign ie.in_valid = v16; assign ie.in_x = x16; assign ie.out_ready = r16;

  sqrt_iter_hs #(.IN_W(32), .BITS_PER_CYC(1), .ROUND(0), .ZERO_CLAMP(1)) u_a (.clk(clk), .reset(reset), .s(ia), .busy(busy_a));
  sqrt_iter_hs #(.IN_W(32), .BITS_PER_CYC(1), .ROUND(0), .ZERO_CLAMP(0)) u_b (.clk(clk), .reset(reset), .s(ib), .busy(busy_b));
  sqrt_iter_hs #(.IN_W(32), .BITS_PER_CYC(1), .ROUND(1), .ZERO_CLAMP(1)) u_c (.clk(clk), .reset(reset), .s(ic), .busy(busy_c));
  sqrt_iter_hs #(.IN_W(16), .BITS_PER_CYC(2), .ROUND(0), .ZERO_CLAMP(1)) u_d (.clk(clk), .reset(reset), .s(id), .busy(busy_d));
  sqrt_iter_hs #(.IN_W(16), .BITS_PER_CYC(2), .ROUND(1), .ZERO_CLAMP(0)) u_e (.clk(clk), .reset(reset), .s(ie), .busy(busy_e));

  function automatic int isqrt(input int x);
    int r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  task automatic start32(input logic [31:0] x, output int lat);
    @(negedge clk);
    v32 = 1'b1; x32 = x;
    @(posedge clk); #1;
    v32 = 1'b0; x32 = 32'hDEAD_BEEF;
    lat = 0;
    while (!ia.out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic ack32();
    r32 = 1'b1;
    @(posedge clk); #1;
    r32 = 1'b0;
  endtask

  task automatic start16(input logic [15:0] x, output int lat);
    v16 = 1'b1; x16 = x;
    @(posedge clk); #1;
    v16 = 1'b0; x16 = 16'hA5A5;
    lat = 0;
    while (!id.out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic ack16();
    r16 = 1'b1;
    @(posedge clk); #1;
    r16 = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({ia.out_valid, ia.out_y, ia.out_rem, busy_a} !== '0) begin errors++; $display("FAIL reset_a: got v=%b y=%0d rem=%0d busy=%b, want all 0", ia.out_valid, ia.out_y, ia.out_rem, busy_a); end
    checks++; if ({id.out_valid, id.out_y, id.out_rem, busy_d} !== '0) begin errors++; $display("FAIL reset_d: got v=%b y=%0d rem=%0d busy=%b, want all 0", id.out_valid, id.out_y, id.out_rem, busy_d); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (ia.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", ia.in_ready); end
  endtask

  task automatic test_zero();
    int lat;
    start32(32'd0, lat);
    checks++; if (lat !== 16) begin errors++; $display("FAIL zero_latency: got %0d want 16", lat); end
    checks++; if (ia.out_y !== 16'd1 || ia.out_rem !== 17'd0) begin errors++; $display("FAIL zero_clamp: got y=%0d rem=%0d want y=1 rem=0", ia.out_y, ia.out_rem); end
    checks++; if (ib.out_y !== 16'd0 || ib.out_rem !== 17'd0) begin errors++; $display("FAIL zero_noclamp: got y=%0d rem=%0d want y=0 rem=0", ib.out_y, ib.out_rem); end
    checks++; if (ic.out_y !== 16'd1) begin errors++; $display("FAIL zero_round_clamp: got y=%0d want 1", ic.out_y); end
    ack32();
  endtask

  task automatic test_small();
    int lat;
    start32(32'd15, lat);
    checks++; if (ia.out_y !== 16'd3 || ia.out_rem !== 17'd6) begin errors++; $display("FAIL x15_floor: got y=%0d rem=%0d want y=3 rem=6", ia.out_y, ia.out_rem); end
    checks++; if (ic.out_y !== 16'd4 || ic.out_rem !== 17'd6) begin errors++; $display("FAIL x15_round: got y=%0d rem=%0d want y=4 rem=6", ic.out_y, ic.out_rem); end
    ack32();
    start32(32'd16, lat);
    checks++; if (ia.out_y !== 16'd4 || ia.out_rem !== 17'd0) begin errors++; $display("FAIL x16_floor: got y=%0d rem=%0d want y=4 rem=0", ia.out_y, ia.out_rem); end
    checks++; if (ic.out_y !== 16'd4 || ic.out_rem !== 17'd0) begin errors++; $display("FAIL x16_round: got y=%0d rem=%0d want y=4 rem=0", ic.out_y, ic.out_rem); end
    ack32();
    start32(32'd1000, lat);
    checks++; if (ia.out_y !== 16'd31 || ia.out_rem !== 17'd39) begin errors++; $display("FAIL x1000_floor: got y=%0d rem=%0d want y=31 rem=39", ia.out_y, ia.out_rem); end
    checks++; if (ic.out_y !== 16'd32) begin errors++; $display("FAIL x1000_round: got y=%0d want 32", ic.out_y); end
    ack32();
  endtask

  task automatic test_max();
    int lat;
    start32(32'hFFFF_FFFF, lat);
    checks++; if (ia.out_y !== 16'd65535 || ia.out_rem !== 17'd131070) begin errors++; $display("FAIL max_floor: got y=%0d rem=%0d want y=65535 rem=131070", ia.out_y, ia.out_rem); end
    checks++; if (ic.out_y !== 16'd65535 || ic.out_rem !== 17'd131070) begin errors++; $display("FAIL max_round_sat: got y=%0d rem=%0d want y=65535 rem=131070", ic.out_y, ic.out_rem); end
    ack32();
  endtask

  task automatic test_back_to_back();
    int lat;
    start32(32'd2, lat);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin v32 = 1'b1; x32 = 32'd9; end
      if (i == 2) begin v32 = 1'b0; end
      @(posedge clk); #1;
      checks++; if (ia.out_valid !== 1'b1 || ia.in_ready !== 1'b0 || ia.out_y !== 16'd1 || ia.out_rem !== 17'd1) begin
        errors++; $display("FAIL stall_%0d: got v=%b rdy=%b y=%0d rem=%0d want v=1 rdy=0 y=1 rem=1", i, ia.out_valid, ia.in_ready, ia.out_y, ia.out_rem);
      end
    end
    ack32();
    checks++; if (ia.in_ready !== 1'b1 || ia.out_valid !== 1'b0) begin errors++; $display("FAIL after_ack: got rdy=%b v=%b want rdy=1 v=0", ia.in_ready, ia.out_valid); end
    v32 = 1'b1; x32 = 32'd1000000;
    @(posedge clk); #1;
    v32 = 1'b0; x32 = '0;
    lat = 0;
    while (!ia.out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    checks++; if (lat !== 16) begin errors++; $display("FAIL b2b_latency: got %0d want 16", lat); end
    checks++; if (ia.out_y !== 16'd1000 || ia.out_rem !== 17'd0) begin errors++; $display("FAIL b2b_result: got y=%0d rem=%0d want y=1000 rem=0", ia.out_y, ia.out_rem); end
    ack32();
  endtask

  task automatic test_reset_abort();
    int lat;
    logic seen;
    @(negedge clk);
    v32 = 1'b1; x32 = 32'd12345;
    @(posedge clk); #1;
    v32 = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    checks++; if ({ia.out_valid, ia.out_y, ia.out_rem, busy_a} !== '0) begin errors++; $display("FAIL abort_clear: got v=%b y=%0d rem=%0d busy=%b want all 0", ia.out_valid, ia.out_y, ia.out_rem, busy_a); end
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (20) begin @(posedge clk); #1; if (ia.out_valid) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_valid: got out_valid=1 want 0"); end
    start32(32'd12345, lat);
    checks++; if (ia.out_y !== 16'd111 || ia.out_rem !== 17'd24) begin errors++; $display("FAIL x12345: got y=%0d rem=%0d want y=111 rem=24", ia.out_y, ia.out_rem); end
    ack32();
  endtask

  task automatic test_w16();
    int lat;
    start16(16'd65535, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL w16_latency: got %0d want 4", lat); end
    checks++; if (id.out_y !== 8'd255 || id.out_rem !== 9'd510) begin errors++; $display("FAIL w16_max: got y=%0d rem=%0d want y=255 rem=510", id.out_y, id.out_rem); end
    checks++; if (ie.out_y !== 8'd255) begin errors++; $display("FAIL w16_max_round_sat: got y=%0d want 255", ie.out_y); end
    ack16();
    start16(16'd0, lat);
    checks++; if (id.out_y !== 8'd1 || ie.out_y !== 8'd0) begin errors++; $display("FAIL w16_zero: got d=%0d e=%0d want d=1 e=0", id.out_y, ie.out_y); end
    ack16();
  endtask

  task automatic test_sweep();
    int lat, x, r, rm, yr;
    for (int n = 0; n < 10000; n++) begin
      x  = (n < 2) ? n * 65535 : int'($urandom_range(0, 65535));
      r  = isqrt(x);
      rm = x - r * r;
      yr = (rm > r && r < 255) ? r + 1 : r;
      start16(16'(x), lat);
      checks++; if (int'(id.out_y) !== ((r == 0) ? 1 : r) || int'(id.out_rem) !== rm) begin
        errors++; $display("FAIL sweep_floor x=%0d: got y=%0d rem=%0d want y=%0d rem=%0d", x, id.out_y, id.out_rem, (r == 0) ? 1 : r, rm);
      end
      checks++; if (int'(ie.out_y) !== yr || int'(ie.out_rem) !== rm) begin
        errors++; $display("FAIL sweep_round x=%0d: got y=%0d rem=%0d want y=%0d rem=%0d", x, ie.out_y, ie.out_rem, yr, rm);
      end
      ack16();
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_small();
    test_max();
    test_back_to_back();
    test_reset_abort();
    test_w16();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
